// File: rtl/fptd_ctrl_pkg.sv
// Shared types and defaults for the turbo-decoder pipeline controllers.
// Holds the Razor sequencer state encoding and default sizing.
package fptd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    RECOVER,
    DONE
  } razor_state_t;

  localparam int NSTAGE_DEF      = 8;
  localparam int ITER_W_DEF      = 8;
  localparam int RECOVER_CYC_DEF = 1;
  localparam int CONSEC_MAX_DEF  = 4;
  localparam int ERRCNT_W_DEF    = 8;

  // Width able to index n items, never collapsing to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/razor_pipe_ctrl_if.sv
// Control/status bundle between the Razor sequencer and its client.
// The master side starts decodes and reports stage errors.
interface razor_pipe_ctrl_if
  import fptd_ctrl_pkg::*;
#(
  parameter int NSTAGE   = NSTAGE_DEF,
  parameter int ITER_W   = ITER_W_DEF,
  parameter int ERRCNT_W = ERRCNT_W_DEF
);

  localparam int SW = idx_w(NSTAGE);

  logic                Start;
  logic [ITER_W-1:0]   NumCyc;
  logic [NSTAGE-1:0]   Error_in;
  logic                Enable;
  logic                nClear;
  logic                Busy;
  logic                Done;
  logic                Abort;
  logic [ERRCNT_W-1:0] ErrCount;
  logic [SW-1:0]       ErrStage;

  modport master (
    output Start,
    output NumCyc,
    output Error_in,
    input  Enable,
    input  nClear,
    input  Busy,
    input  Done,
    input  Abort,
    input  ErrCount,
    input  ErrStage
  );

  modport slave (
    input  Start,
    input  NumCyc,
    input  Error_in,
    output Enable,
    output nClear,
    output Busy,
    output Done,
    output Abort,
    output ErrCount,
    output ErrStage
  );

endinterface

// File: rtl/razor_err_prienc.sv
// Lowest-set-bit encoder over the per-stage Razor error flags.
// Gives the OR of all flags and the index of the lowest one set.
module razor_err_prienc
  import fptd_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF
) (
  input  logic [NSTAGE-1:0]        err,
  output logic                     any,
  output logic [idx_w(NSTAGE)-1:0] idx
);

  localparam int SW = idx_w(NSTAGE);

  always_comb begin
    any = |err;
    idx = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (err[i]) idx = SW'(i);
    end
  end

endmodule

// File: rtl/razor_pipe_ctrl.sv
// Decode sequencer with Razor timing-error replay for the extrinsic stages.
// Drops Enable for a replay window on any stage error; aborts on error bursts.
module razor_pipe_ctrl
  import fptd_ctrl_pkg::*;
#(
  parameter int NSTAGE      = NSTAGE_DEF,
  parameter int ITER_W      = ITER_W_DEF,
  parameter int RECOVER_CYC = RECOVER_CYC_DEF,
  parameter int CONSEC_MAX  = CONSEC_MAX_DEF,
  parameter int ERRCNT_W    = ERRCNT_W_DEF
) (
  input logic               Clock,
  input logic               nReset,
  razor_pipe_ctrl_if.slave  io
);

  localparam int SW = idx_w(NSTAGE);
  localparam int CW = idx_w(CONSEC_MAX + 1);
  localparam int RW = idx_w(RECOVER_CYC);

  localparam logic [CW-1:0] CMAX  = CW'(CONSEC_MAX);
  localparam logic [RW-1:0] RLAST = RW'(RECOVER_CYC - 1);

  razor_state_t state, state_d;

  logic [ITER_W-1:0]   req, req_d;
  logic [ITER_W-1:0]   cyc_cnt, cyc_d;
  logic [CW-1:0]       consec, consec_d;
  logic [RW-1:0]       rec_cnt, rec_d;
  logic [ERRCNT_W-1:0] err_cnt, err_cnt_d;
  logic [SW-1:0]       err_stage, err_stage_d;
  logic                abort_q, abort_d;

  logic en_q, nclr_q, busy_q, done_q;
  logic en_d, nclr_d, busy_d, done_d;

  logic          err_any;
  logic [SW-1:0] err_idx;

  razor_err_prienc #(
    .NSTAGE (NSTAGE)
  ) u_prienc (
    .err (io.Error_in),
    .any (err_any),
    .idx (err_idx)
  );

  always_comb begin
    state_d     = state;
    req_d       = req;
    cyc_d       = cyc_cnt;
    consec_d    = consec;
    rec_d       = rec_cnt;
    err_cnt_d   = err_cnt;
    err_stage_d = err_stage;
    abort_d     = abort_q;

    unique case (state)
      IDLE: begin
        if (io.Start) begin
          req_d   = io.NumCyc;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cyc_d       = '0;
        consec_d    = '0;
        err_cnt_d   = '0;
        err_stage_d = '0;
        abort_d     = 1'b0;
        state_d     = (req == '0) ? DONE : RUN;
      end
      RUN: begin
        if (err_any) begin
          consec_d = consec + CW'(1);
          // The burst-ending error is an abort, not a recovery.
          if (consec + CW'(1) == CMAX) begin
            abort_d = 1'b1;
            state_d = DONE;
          end else begin
            err_cnt_d   = (&err_cnt) ? err_cnt
                                     : err_cnt + ERRCNT_W'(1);
            err_stage_d = err_idx;
            rec_d       = '0;
            state_d     = RECOVER;
          end
        end else begin
          cyc_d    = cyc_cnt + ITER_W'(1);
          consec_d = '0;
          if (cyc_cnt + ITER_W'(1) == req) state_d = DONE;
        end
      end
      RECOVER: begin
        if (rec_cnt == RLAST) state_d = RUN;
        else rec_d = rec_cnt + RW'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    en_d   = (state_d == RUN);
    nclr_d = (state_d != CLEAR);
    busy_d = (state_d == CLEAR) ||
             (state_d == RUN) ||
             (state_d == RECOVER);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      req       <= '0;
      cyc_cnt   <= '0;
      consec    <= '0;
      rec_cnt   <= '0;
      err_cnt   <= '0;
      err_stage <= '0;
      abort_q   <= 1'b0;
      en_q      <= 1'b0;
      nclr_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      req       <= req_d;
      cyc_cnt   <= cyc_d;
      consec    <= consec_d;
      rec_cnt   <= rec_d;
      err_cnt   <= err_cnt_d;
      err_stage <= err_stage_d;
      abort_q   <= abort_d;
      en_q      <= en_d;
      nclr_q    <= nclr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign io.Enable   = en_q;
  assign io.nClear   = nclr_q;
  assign io.Busy     = busy_q;
  assign io.Done     = done_q;
  assign io.Abort    = abort_q;
  assign io.ErrCount = err_cnt;
  assign io.ErrStage = err_stage;

endmodule

// File: doc/razor_pipe_ctrl.md
# razor_pipe_ctrl

Sequencing and error-recovery controller for the Razor-protected extrinsic pipeline stages of the turbo decoder. It runs a decode for a programmed number of enabled cycles and pulses a clear to the stages at the start. It ORs the per-stage timing-error flags and, on any error, drops the shared `Enable` for a fixed replay window so the shadow latches can resolve. It counts recoveries and aborts the decode if errors persist back-to-back.

## Interface
Parameters:
- `NSTAGE`, 8: number of Razor stages reporting an error flag.
- `ITER_W`, 8: width of the cycle-count request.
- `RECOVER_CYC`, 1: cycles `Enable` is held low per recovery (≥1).
- `CONSEC_MAX`, 4: consecutive recoveries that trigger abort (≥1).
- `ERRCNT_W`, 8: width of the error counter.

Ports:
- `Clock`, in, 1: single clock, rising edge.
- `nReset`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: begin decode. Honoured only in IDLE.
- `NumCyc`, in, `ITER_W`: enabled cycles requested. Sampled with `Start`.
- `Error_in`, in, `NSTAGE`: per-stage `Error_current` flags.
- `Enable`, out, 1: shared stage enable. Registered.
- `nClear`, out, 1: synchronous clear to stages, active-low. Registered.
- `Busy`, out, 1: high in CLEAR, RUN and RECOVER.
- `Done`, out, 1: one-cycle pulse at end of decode.
- `Abort`, out, 1: set when the consecutive-error limit is hit. Holds until the next CLEAR.
- `ErrCount`, out, `ERRCNT_W`: recoveries this decode. Saturating.
- `ErrStage`, out, `$clog2(NSTAGE)`: lowest erroring index at the most recent recovery.

## Operation
FSM states: IDLE, CLEAR, RUN, RECOVER, DONE.
- **IDLE**
  - Outputs: `Enable`=0, `nClear`=1, `Busy`=0.
  - `Start`=1 latches `NumCyc` into `req` and goes to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - Outputs: `nClear`=0, `Enable`=0.
  - Zeroes `cyc_cnt`, `consec`, `ErrCount`, `ErrStage` and `Abort`.
  - Next state: RUN, or DONE if `req`==0.
- **RUN**: `Enable`=1. Each cycle, evaluated with priority in this order:
  - `|Error_in`=1: go to RECOVER; `cyc_cnt` is unchanged.
    - `ErrCount` is incremented, saturating at all-ones.
    - `ErrStage` is loaded with the lowest set index.
    - `consec` is incremented. If `consec`+1 == `CONSEC_MAX`, set `Abort` and go to DONE instead.
  - Otherwise: `cyc_cnt`++ and `consec` is cleared. If `cyc_cnt`+1 == `req`, go to DONE.
- **RECOVER**
  - `Enable`=0 for `RECOVER_CYC` cycles, timed by `rec_cnt`, then back to RUN.
  - `Error_in` is ignored (masked) throughout.
- **DONE**
  - `Done`=1 and `Enable`=0 for 1 cycle, then IDLE.
  - `ErrCount`, `ErrStage` and `Abort` hold until the next CLEAR.
- `Start` outside IDLE is ignored. `NumCyc` changes after sampling have no effect.
- Reset values: `Enable`=0, `nClear`=1, `Busy`=0, `Done`=0, `Abort`=0, `ErrCount`=0, `ErrStage`=0, state IDLE. All counters 0.

## Timing
- All outputs are registered, so state changes are visible in the cycle after the deciding edge.
- Nominal decode, `Start` sampled at edge k:
  - CLEAR visible k+1 to k+2.
  - `Enable`=1 from k+2 for `req` cycles.
  - `Done` pulses in the cycle that begins `req`+2 edges after k.
- Each recovery adds `RECOVER_CYC` low-`Enable` cycles. The errored RUN cycle itself is not counted.
- Error on the final needed RUN cycle: recovery takes priority; DONE follows the next clean RUN cycle.
- `nReset` asserted mid-decode: all outputs go to their reset values asynchronously, and `Enable` drops immediately. The decode is lost, with no `Done`.
- `Error_in` is sampled only in RUN. Glitches in other states have no effect.

## Structure
- Shared package `fptd_ctrl_pkg`:
  - state enum `razor_state_t` (IDLE, CLEAR, RUN, RECOVER, DONE);
  - default parameter constants.
- Sub-module `razor_err_prienc #(NSTAGE)`: combinational lowest-set-bit encoder giving `any` and `idx`. It is used for `ErrStage` and for the OR.
- The rest (FSM plus four counters) stays in one module.

## Test plan
- **Nominal:** `NumCyc`=5, `Error_in`=0.
  - `Enable` high exactly 5 cycles.
  - `nClear` low 1 cycle before them.
  - `Done` the following cycle; `ErrCount`=0.
- **Single error:** `NumCyc`=5, `Error_in`=8'h24 in the 3rd RUN cycle, `RECOVER_CYC`=2.
  - `Enable` pattern 1,1,1,0,0,1,1,1.
  - `ErrCount`=1, `ErrStage`=2, `Done` after 6 RUN cycles.
- **Masking:** `Error_in`=all-ones held through RECOVER, then 0.
  - Exactly one recovery counted; `ErrCount`=1.
- **Abort:** `CONSEC_MAX`=4, error on every RUN cycle.
  - `Abort`=1 and `Done` after the 4th errored cycle.
  - `ErrCount`=3 (4th not taken as recovery); `Enable` never high 2 cycles in a row.
- **Edge cases:**
  - `NumCyc`=0: CLEAR then `Done` with no `Enable`.
  - `Start` during RUN: ignored.
  - `ErrCount` saturation with `ERRCNT_W`=2: stays at 3.
- **Reset mid-RUN:** `nReset` pulsed low.
  - `Enable`=0 and `Busy`=0 with no clock edge; no `Done`.
  - A subsequent `Start` decodes normally.
